// File: rtl/sqrt_pkg.sv
// Purpose : shared types and helpers for the square-root sequencer.
// Contents: sqrt_state_t (sequencer state), DW_DEF (default radicand width),
//           sqrt_shamt() (datapath right-shift amount for iteration k).
package sqrt_pkg;

    localparam int DW_DEF = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } sqrt_state_t;

    // Radicand bit pairs are consumed MSB-first, so iteration k shifts the
    // radicand right by 2*(half-1-k); half is the number of root bits.
    function automatic int unsigned sqrt_shamt(input int unsigned half, input int unsigned k);
        return 2 * (half - 1 - k);
    endfunction

endpackage

// File: rtl/sqrt_rem_fix.sv
// Purpose : final remainder correction for the non-restoring square root.
//           A negative datapath remainder is brought back into range by
//           adding 2*root+1; a non-negative one passes through unchanged.
// Ports   : q     in  DW/2  final partial root from the datapath
//           rem   in  RW    final partial remainder, two's complement
//           fixed out RW    corrected remainder
//           fired out 1     correction was applied
module sqrt_rem_fix #(
    parameter int DW = 16,
    parameter int RW = DW / 2 + 1
) (
    input  logic [DW/2-1:0] q,
    input  logic [RW-1:0]   rem,
    output logic [RW-1:0]   fixed,
    output logic            fired
);

    logic [RW-1:0] odd_root;

    // 2*q+1, sized to the remainder width so the add wraps at RW bits.
    assign odd_root = RW'({q, 1'b1});
    assign fired    = rem[RW-1];
    assign fixed    = fired ? rem + odd_root : rem;

endmodule

// File: rtl/sqrt_seq_ctrl.sv
// Purpose : sequencer for the non-restoring square-root datapath (sqrt_add).
//           Accepts a radicand, clears the datapath, steps it DW/2 times,
//           corrects a negative remainder and presents root/remainder.
// Ports   : clk, reset (async, active high)
//           in_valid/in_ready/in_data   radicand handshake
//           dp_clr, dp_load, dp_d, dp_excounter   datapath control
//           dp_q, dp_rem                datapath partial root / remainder
//           out_valid/out_ready/out_root/out_rem  result handshake
//           busy                        high whenever not IDLE
module sqrt_seq_ctrl
    import sqrt_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = DW / 2 + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic            dp_clr,
    output logic            dp_load,
    output logic [DW-1:0]   dp_d,
    output logic [DW-1:0]   dp_excounter,
    input  logic [DW/2-1:0] dp_q,
    input  logic [RW-1:0]   dp_rem,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW/2-1:0] out_root,
    output logic [RW-1:0]   out_rem,
    output logic            busy
);

    localparam int            HALF   = DW / 2;
    localparam int            KW     = $clog2(HALF) + 1;
    localparam logic [KW-1:0] K_LAST = KW'(HALF - 1);

    sqrt_state_t   state, state_next;
    logic [KW-1:0] k;
    logic [RW-1:0] rem_fixed;
    logic          rem_fired;

    sqrt_rem_fix #(.DW(DW), .RW(RW)) u_rem_fix (
        .q     (dp_q),
        .rem   (dp_rem),
        .fixed (rem_fixed),
        .fired (rem_fired)
    );

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            k        <= '0;
            dp_d     <= '0;
            out_root <= '0;
            out_rem  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (in_valid) dp_d <= in_data;
                CLR:  k <= '0;
                ITER: k <= k + KW'(1);
                FIX: begin
                    out_root <= dp_q;
                    out_rem  <= rem_fixed;
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block gets a default before the case, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        in_ready     = 1'b0;
        dp_clr       = 1'b0;
        dp_load      = 1'b1;
        dp_excounter = '0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_next = CLR;
            end
            CLR: begin
                dp_clr     = 1'b1;
                state_next = ITER;
            end
            ITER: begin
                dp_load      = 1'b0;
                dp_excounter = DW'(sqrt_shamt(HALF, int'(k)));
                if (k == K_LAST) state_next = FIX;
            end
            FIX: begin
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // rem_fired is informational only; keep it referenced.
    logic unused_fired;
    assign unused_fired = rem_fired;

endmodule

// File: tb/tb_sqrt_seq_ctrl.sv
// Purpose : directed self-checking bench for sqrt_seq_ctrl (DW=16) with a
//           behavioural model of the sqrt_add datapath attached.
module tb_sqrt_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        dp_clr;
    logic        dp_load;
    logic [15:0] dp_d;
    logic [15:0] dp_excounter;
    logic [7:0]  dp_q;
    logic [8:0]  dp_rem;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_root;
    logic [8:0]  out_rem;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sqrt_seq_ctrl #(.DW(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .dp_clr       (dp_clr),
        .dp_load      (dp_load),
        .dp_d         (dp_d),
        .dp_excounter (dp_excounter),
        .dp_q         (dp_q),
        .dp_rem       (dp_rem),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_root     (out_root),
        .out_rem      (out_rem),
        .busy         (busy)
    );

    // ---------------- datapath model (sqrt_add) ----------------
    // Non-restoring step on the bit pair selected by dp_excounter. The
    // remainder is kept wide; the 9-bit view keeps values above 255 in the
    // equivalent negative form D-(Q+1)^2 so they remain representable.
    int m_q = 0;
    int m_r = 0;
    int rep;

    always @(posedge clk) begin : dp_model
        int pair;
        int nr;
        if (dp_clr) begin
            m_q <= 0;
            m_r <= 0;
        end else if (!dp_load) begin
            pair = int'((dp_d >> dp_excounter) & 16'd3);
            if (m_r >= 0) nr = 4 * m_r + pair - (4 * m_q + 1);
            else          nr = 4 * m_r + pair + (4 * m_q + 3);
            m_r <= nr;
            m_q <= (2 * m_q) + ((nr >= 0) ? 1 : 0);
        end
    end

    always_comb begin
        rep = m_r;
        if (m_r > 255) rep = m_r - (2 * m_q + 1);
        dp_rem = rep[8:0];
        dp_q   = m_q[7:0];
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),     1);
        check({tag, "_dp_clr"},    32'(dp_clr),       0);
        check({tag, "_dp_load"},   32'(dp_load),      1);
        check({tag, "_dp_d"},      32'(dp_d),         0);
        check({tag, "_excnt"},     32'(dp_excounter), 0);
        check({tag, "_out_valid"}, 32'(out_valid),    0);
        check({tag, "_out_root"},  32'(out_root),     0);
        check({tag, "_out_rem"},   32'(out_rem),      0);
        check({tag, "_busy"},      32'(busy),         0);
    endtask

    // Offer d until accepted; returns just after the accepting edge.
    task automatic send(input logic [15:0] d);
        int t;
        t = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("send_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Counts negedges after the accepting edge until out_valid is seen.
    task automatic wait_valid(input string tag, output int n, output logic fired);
        n     = 0;
        fired = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (n == 10) fired = dp_rem[8];
        end while (!out_valid && n < 100);
        check({tag, "_valid"}, 32'(out_valid), 1);
    endtask

    // Full transaction with out_ready high; ends back in IDLE at a negedge.
    task automatic do_run(input string tag, input logic [15:0] d,
                          input logic [7:0] exp_root, input logic [8:0] exp_rem,
                          output logic fired);
        int n;
        send(d);
        wait_valid(tag, n, fired);
        check({tag, "_latency"}, 32'(n), 11);
        check({tag, "_root"}, 32'(out_root), 32'(exp_root));
        check({tag, "_rem"},  32'(out_rem),  32'(exp_rem));
        @(negedge clk);
        check({tag, "_idle_valid"}, 32'(out_valid), 0);
        check({tag, "_idle_ready"}, 32'(in_ready),  1);
    endtask

    initial begin
        logic fired;
        int   n;
        int   last_acc;
        int   acc_count;
        int   it;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;
        @(negedge clk);

        // 1..3: basic roots, including the negative-remainder correction
        do_run("zero", 16'd0, 8'd0, 9'd0, fired);
        do_run("r144", 16'd144, 8'd12, 9'd0, fired);
        do_run("r200", 16'd200, 8'd14, 9'd4, fired);
        do_run("rmax", 16'd65535, 8'd255, 9'd510, fired);
        check("rmax_fix_fired", 32'(fired), 1);
        do_run("r81a", 16'd81, 8'd9, 9'd0, fired);
        check("r81a_no_fix", 32'(fired), 0);

        // 4: consumer stalls for 20 cycles; input changes are ignored
        out_ready = 1'b0;
        send(16'd17);
        in_data = 16'h1234;
        wait_valid("stall", n, fired);
        for (int i = 0; i < 20; i++) begin
            check("stall_valid", 32'(out_valid), 1);
            check("stall_root",  32'(out_root),  4);
            check("stall_rem",   32'(out_rem),   1);
            check("stall_ready", 32'(in_ready),  0);
            check("stall_dp_d",  32'(dp_d),      17);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_one_beat", 32'(out_valid), 0);
        check("stall_idle",     32'(in_ready),  1);
        @(negedge clk);
        check("stall_stay_idle", 32'(out_valid), 0);

        // 5: asynchronous reset in the middle of ITER (k=3)
        send(16'd40000);
        repeat (5) @(negedge clk);
        check("mid_excnt_k3", 32'(dp_excounter), 8);
        reset = 1'b1;
        #1 check_reset_vals("rst_async");
        @(negedge clk);
        check_reset_vals("rst_next");
        reset = 1'b0;
        @(negedge clk);
        do_run("r81b", 16'd81, 8'd9, 9'd0, fired);

        // 6: back-to-back requests with out_ready held high
        in_data   = 16'd200;
        in_valid  = 1'b1;
        last_acc  = -1;
        acc_count = 0;
        it        = 0;
        for (int c = 0; c < 40; c++) begin
            if (in_ready) begin
                if (last_acc >= 0) check("b2b_gap", 32'(c - last_acc), 12);
                last_acc = c;
                acc_count++;
            end
            if (!dp_load) begin
                check("b2b_excnt", dp_excounter, 32'(14 - 2 * it));
                it++;
            end else begin
                it = 0;
            end
            if (out_valid) begin
                check("b2b_root", 32'(out_root), 14);
                check("b2b_rem",  32'(out_rem),  4);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("b2b_accepts", 32'(acc_count), 4);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b2b_drain_valid", 32'(out_valid), 1);
        check("b2b_drain_root",  32'(out_root),  14);
        @(negedge clk);
        check("b2b_drain_idle", 32'(in_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
